// File: rtl/linebuf_fetch_ctl_if.sv
// linebuf_fetch_ctl_if: line control, video memory read and line buffer write signals
// master: the fetch controller (drives mem_req/adr, lb_* writes, bank/busy/underrun)
// slave:  the surrounding system (line timing, memory arbiter, line buffer)
interface linebuf_fetch_ctl_if #(parameter int AW = 9, parameter int MEM_AW = 20);
  logic hsync_start_i;
  logic vblank_i;
  logic line_start_i;
  logic [MEM_AW-1:0] line_base_i;
  logic [AW-1:0] words_i;
  logic mem_req_o;
  logic [MEM_AW-1:0] mem_adr_o;
  logic mem_ack_i;
  logic [15:0] mem_dat_i;
  logic lb_we_o;
  logic [AW:0] lb_wadr_o;
  logic [15:0] lb_wdat_o;
  logic bank_o;
  logic busy_o;
  logic underrun_o;
  modport master (
    input hsync_start_i, vblank_i, line_start_i, line_base_i, words_i, mem_ack_i, mem_dat_i,
    output mem_req_o, mem_adr_o, lb_we_o, lb_wadr_o, lb_wdat_o, bank_o, busy_o, underrun_o
  );
  modport slave (
    output hsync_start_i, vblank_i, line_start_i, line_base_i, words_i, mem_ack_i, mem_dat_i,
    input mem_req_o, mem_adr_o, lb_we_o, lb_wadr_o, lb_wdat_o, bank_o, busy_o, underrun_o
  );
endinterface

// File: rtl/linebuf_fetch_ctl.sv
// linebuf_fetch_ctl: fetches one scanline from video memory into the back bank of a double-buffered line buffer
// dotclk_i/rst_i: dot clock and asynchronous active-high reset
// bus (master): hsync/vblank/line_start timing, line_base/words, mem req/adr/ack/dat,
//               lb we/wadr/wdat, front bank, busy and underrun pulse
module linebuf_fetch_ctl #(parameter int AW = 9, parameter int MEM_AW = 20) (
  input logic dotclk_i,
  input logic rst_i,
  linebuf_fetch_ctl_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;
  state_t r_state;
  logic r_req;
  logic r_we;
  logic r_bank;
  logic r_busy;
  logic r_under;
  logic [MEM_AW-1:0] r_adr;
  logic [AW:0] r_wadr;
  logic [15:0] r_wdat;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic w_start;
  logic w_last;
  assign w_start = bus.hsync_start_i & ~bus.vblank_i & (bus.words_i != '0);
  assign w_last = r_idx == r_cnt - AW'(1);
  always_ff @(posedge dotclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_req <= 1'b0;
      r_we <= 1'b0;
      r_bank <= 1'b0;
      r_busy <= 1'b0;
      r_under <= 1'b0;
      r_adr <= '0;
      r_wadr <= '0;
      r_wdat <= '0;
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_we <= 1'b0;
      r_under <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          r_cnt <= bus.words_i;
          r_idx <= '0;
          r_adr <= bus.line_base_i;
          r_req <= 1'b1;
          r_busy <= 1'b1;
          r_state <= FETCH;
        end
        FETCH: begin
          // every accepted word is written, even one arriving with an abort
          if (bus.mem_ack_i) begin
            r_we <= 1'b1;
            r_wadr <= {~r_bank, r_idx};
            r_wdat <= bus.mem_dat_i;
            r_idx <= r_idx + AW'(1);
            r_adr <= r_adr + MEM_AW'(1);
          end
          if (bus.mem_ack_i && w_last) begin
            r_req <= 1'b0;
            r_busy <= 1'b0;
            r_bank <= r_bank ^ bus.line_start_i;
            r_state <= bus.line_start_i ? IDLE : READY;
          end else if (bus.line_start_i) begin
            // display caught up with an unfinished line: keep showing the old bank
            r_req <= 1'b0;
            r_busy <= 1'b0;
            r_under <= 1'b1;
            r_state <= IDLE;
          end
        end
        READY: if (bus.line_start_i) begin
          r_bank <= ~r_bank;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.mem_req_o = r_req;
  assign bus.mem_adr_o = r_adr;
  assign bus.lb_we_o = r_we;
  assign bus.lb_wadr_o = r_wadr;
  assign bus.lb_wdat_o = r_wdat;
  assign bus.bank_o = r_bank;
  assign bus.busy_o = r_busy;
  assign bus.underrun_o = r_under;
endmodule

// File: tb/tb_linebuf_fetch_ctl.sv
// tb_linebuf_fetch_ctl: directed self-checking bench for linebuf_fetch_ctl
module tb_linebuf_fetch_ctl;
  localparam int AW = 9;
  localparam int MEM_AW = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_n = 0;
  int tot_n = 0;
  int fail_n = 0;
  int lat = 0;
  int wait_n = 0;
  int writes = 0;
  int acks = 0;
  logic exp_bank = 1'b0;
  logic [AW-1:0] exp_idx = '0;
  logic [MEM_AW-1:0] exp_adr = '0;
  logic [AW:0] q_adr[$];
  logic [15:0] q_dat[$];
  logic [3:0] we_v;
  logic [3:0] req_v;
  always #5 clk = ~clk;
  linebuf_fetch_ctl_if #(.AW(AW), .MEM_AW(MEM_AW)) bus ();
  linebuf_fetch_ctl #(.AW(AW), .MEM_AW(MEM_AW)) dut (.dotclk_i(clk), .rst_i(rst), .bus(bus));
  function automatic logic [15:0] mdat(input logic [MEM_AW-1:0] a);
    return a[15:0] ^ {a[19:16], a[19:16], 8'h5A};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_n++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL #%0d %s observed=0x%0h expected=0x%0h", fail_n, tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [31:0] ea;
    logic [31:0] ed;
    @(posedge clk);
    @(negedge clk);
    if (bus.lb_we_o) begin
      writes++;
      ea = q_adr.size() != 0 ? 32'(q_adr[0]) : 32'hFFFF_FFFF;
      ed = q_dat.size() != 0 ? 32'(q_dat[0]) : 32'hFFFF_FFFF;
      if (q_adr.size() != 0) begin
        void'(q_adr.pop_front());
        void'(q_dat.pop_front());
      end
      chk("lb_wadr", 32'(bus.lb_wadr_o), ea);
      chk("lb_wdat", 32'(bus.lb_wdat_o), ed);
    end
    if (!rst && bus.mem_req_o && wait_n >= lat) begin
      chk("mem_adr", 32'(bus.mem_adr_o), 32'(exp_adr));
      bus.mem_ack_i = 1'b1;
      bus.mem_dat_i = mdat(bus.mem_adr_o);
      q_adr.push_back({~exp_bank, exp_idx});
      q_dat.push_back(mdat(exp_adr));
      exp_adr++;
      exp_idx++;
      acks++;
      wait_n = 0;
    end else begin
      bus.mem_ack_i = 1'b0;
      bus.mem_dat_i = 16'hDEAD;
      wait_n = bus.mem_req_o ? wait_n + 1 : 0;
    end
  endtask
  task automatic start_line(input logic [MEM_AW-1:0] base, input logic [AW-1:0] n, input int l);
    lat = l;
    wait_n = 0;
    acks = 0;
    writes = 0;
    exp_adr = base;
    exp_idx = '0;
    bus.hsync_start_i = 1'b1;
    bus.line_base_i = base;
    bus.words_i = n;
    tick();
    bus.hsync_start_i = 1'b0;
    bus.line_base_i = '1;
    bus.words_i = '0;
    chk("start_req", 32'(bus.mem_req_o), 1);
    chk("start_busy", 32'(bus.busy_o), 1);
    chk("start_adr", 32'(bus.mem_adr_o), 32'(base));
  endtask
  task automatic run_until_acks(input int n, input int budget);
    int k = 0;
    while (acks < n && k < budget) begin
      tick();
      k++;
    end
    chk("ack_budget", acks, n);
  endtask
  task automatic run_until_idle(input int budget);
    int k = 0;
    while (bus.busy_o && k < budget) begin
      tick();
      k++;
    end
    chk("busy_budget", 32'(bus.busy_o), 0);
  endtask
  task automatic pulse_line_start();
    bus.line_start_i = 1'b1;
    tick();
    bus.line_start_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.hsync_start_i = 1'b0;
    bus.vblank_i = 1'b0;
    bus.line_start_i = 1'b0;
    bus.line_base_i = '0;
    bus.words_i = '0;
    bus.mem_ack_i = 1'b0;
    bus.mem_dat_i = '0;
    tick();
    tick();
    chk("rst_req", 32'(bus.mem_req_o), 0);
    chk("rst_we", 32'(bus.lb_we_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_under", 32'(bus.underrun_o), 0);
    chk("rst_bank", 32'(bus.bank_o), 0);
    chk("rst_adr", 32'(bus.mem_adr_o), 0);
    chk("rst_wadr", 32'(bus.lb_wadr_o), 0);
    chk("rst_wdat", 32'(bus.lb_wdat_o), 0);
    rst = 1'b0;
    // full line, ack two cycles after each request
    start_line(20'h01000, 9'd40, 2);
    run_until_idle(400);
    chk("t1_writes", writes, 40);
    chk("t1_req", 32'(bus.mem_req_o), 0);
    chk("t1_bank_ready", 32'(bus.bank_o), 0);
    chk("t1_qleft", q_adr.size(), 0);
    bus.hsync_start_i = 1'b1;
    bus.words_i = 9'd5;
    pulse_line_start();
    bus.hsync_start_i = 1'b0;
    bus.words_i = '0;
    exp_bank = 1'b1;
    chk("t1_bank", 32'(bus.bank_o), 1);
    chk("t1_busy_after_swap", 32'(bus.busy_o), 0);
    tick();
    chk("t1_req_after_swap", 32'(bus.mem_req_o), 0);
    // continuous ack, three words
    start_line(20'h01000, 9'd3, 0);
    we_v = '0;
    req_v = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      we_v = {we_v[2:0], bus.lb_we_o};
      req_v = {req_v[2:0], bus.mem_req_o};
    end
    chk("t2_we_seq", 32'(we_v), 32'hE);
    chk("t2_req_seq", 32'(req_v), 32'hC);
    chk("t2_writes", writes, 3);
    chk("t2_busy", 32'(bus.busy_o), 0);
    pulse_line_start();
    exp_bank = 1'b0;
    chk("t2_bank", 32'(bus.bank_o), 0);
    // abort after ten words
    start_line(20'h02000, 9'd40, 2);
    run_until_acks(10, 100);
    tick();
    pulse_line_start();
    chk("t3_under", 32'(bus.underrun_o), 1);
    chk("t3_req", 32'(bus.mem_req_o), 0);
    chk("t3_busy", 32'(bus.busy_o), 0);
    chk("t3_bank", 32'(bus.bank_o), 0);
    chk("t3_writes", writes, 10);
    tick();
    chk("t3_under_pulse", 32'(bus.underrun_o), 0);
    chk("t3_req_idle", 32'(bus.mem_req_o), 0);
    // final ack together with line_start
    start_line(20'h03000, 9'd40, 1);
    run_until_acks(40, 200);
    pulse_line_start();
    exp_bank = 1'b1;
    chk("t4_bank", 32'(bus.bank_o), 1);
    chk("t4_under", 32'(bus.underrun_o), 0);
    chk("t4_busy", 32'(bus.busy_o), 0);
    chk("t4_req", 32'(bus.mem_req_o), 0);
    chk("t4_writes", writes, 40);
    tick();
    chk("t4_under_later", 32'(bus.underrun_o), 0);
    // suppressed starts and line_start in IDLE
    bus.vblank_i = 1'b1;
    bus.hsync_start_i = 1'b1;
    bus.words_i = 9'd5;
    tick();
    bus.hsync_start_i = 1'b0;
    bus.vblank_i = 1'b0;
    chk("t5_vblank_req", 32'(bus.mem_req_o), 0);
    chk("t5_vblank_busy", 32'(bus.busy_o), 0);
    bus.hsync_start_i = 1'b1;
    bus.words_i = '0;
    tick();
    bus.hsync_start_i = 1'b0;
    chk("t5_zero_req", 32'(bus.mem_req_o), 0);
    tick();
    chk("t5_zero_busy", 32'(bus.busy_o), 0);
    pulse_line_start();
    chk("t5_bank", 32'(bus.bank_o), 1);
    chk("t5_under", 32'(bus.underrun_o), 0);
    // asynchronous reset in the middle of a fetch
    start_line(20'h00100, 9'd40, 2);
    run_until_acks(3, 50);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_req", 32'(bus.mem_req_o), 0);
    chk("t6_rst_busy", 32'(bus.busy_o), 0);
    chk("t6_rst_we", 32'(bus.lb_we_o), 0);
    chk("t6_rst_adr", 32'(bus.mem_adr_o), 0);
    chk("t6_rst_wadr", 32'(bus.lb_wadr_o), 0);
    chk("t6_rst_wdat", 32'(bus.lb_wdat_o), 0);
    chk("t6_rst_bank", 32'(bus.bank_o), 0);
    bus.mem_ack_i = 1'b0;
    q_adr.delete();
    q_dat.delete();
    exp_bank = 1'b0;
    tick();
    rst = 1'b0;
    // address wrap at the top of memory
    start_line(20'hFFFFE, 9'd4, 0);
    run_until_idle(20);
    chk("t6_writes", writes, 4);
    chk("t6_adr_end", 32'(bus.mem_adr_o), 32'h2);
    pulse_line_start();
    chk("t6_bank", 32'(bus.bank_o), 1);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
